lsu: RTL and testbench

- Load/store unit on the consuming end of the ALU's memory operations.
- Takes the alucode (ALU_LB..ALU_SW) and the effective address the ALU computed, and performs the access on a synchronous word-wide data memory.
- Handles byte-lane steering and load sign/zero extension, and returns the result to the writeback stage through a valid/ready handshake.
- Sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu.sv | 125 ++++++++++++
 tb/tb_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: ALU memory opcodes, FSM states
// and opcode classification helpers.
package lsu_pkg;

  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_WAIT   = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input logic [5:0] code);
    return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
           (code == ALU_LBU) || (code == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
// Build option: LSU_MISALIGN_CHECK_EN enables the misalign flag for halfword/word accesses.
module lsu_align import lsu_pkg::*; (
  input  logic [5:0]  alucode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords always use addr[1]; for aligned accesses this equals the byte offset.
  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    we        = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (alucode)
      ALU_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      ALU_LBU: load_data = {24'h0, byte_lane};
      ALU_LH:  load_data = {{16{half_lane[15]}}, half_lane};
      ALU_LHU: load_data = {16'h0, half_lane};
      ALU_LW:  load_data = rdata;
      ALU_SB: begin
        we    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      ALU_SH: begin
        we    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      ALU_SW: begin
        we    = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if ((alucode == ALU_LH) || (alucode == ALU_LHU) || (alucode == ALU_SH))
      misalign = addr_lo[0];
    else if ((alucode == ALU_LW) || (alucode == ALU_SW))
      misalign = (addr_lo != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: request FSM, read latency counter and output registers around lsu_align.
// Build option: LSU_MISALIGN_CHECK_EN (alignment errors, handled inside lsu_align).
module lsu import lsu_pkg::*; #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_re,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  lsu_state_t  state, next_state;
  logic [5:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  cnt;
  logic [5:0]  align_code;
  logic [1:0]  align_lo;
  logic [3:0]  align_we;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        align_misalign;
  logic        req_err;

  assign req_ready = (state == LSU_IDLE);

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign align_code = (state == LSU_IDLE) ? alucode : op_q;
  assign align_lo   = (state == LSU_IDLE) ? addr[1:0] : addr_lo_q;
  assign req_err    = !(is_load(alucode) || is_store(alucode)) || align_misalign;

  lsu_align u_align (
    .alucode    (align_code),
    .addr_lo    (align_lo),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .we         (align_we),
    .wdata      (align_wdata),
    .load_data  (align_load),
    .misalign   (align_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LSU_IDLE:   if (req_valid) next_state = req_err ? LSU_RESP : LSU_ACCESS;
      LSU_ACCESS: next_state = is_load(op_q) ? LSU_WAIT : LSU_RESP;
      LSU_WAIT:   if (cnt == CNT_LAST) next_state = LSU_RESP;
      LSU_RESP:   if (rsp_ready) next_state = LSU_IDLE;
      default:    next_state = LSU_IDLE;
    endcase
  end

  // Strobes are loaded on accept so they are visible exactly during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 6'h0;
      addr_lo_q  <= 2'b00;
      cnt        <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'h0;
      rsp_err    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_re    <= 1'b0;
      dmem_we    <= 4'b0000;
      dmem_wdata <= 32'h0;
    end else begin
      dmem_re <= 1'b0;
      dmem_we <= 4'b0000;
      case (state)
        LSU_IDLE: if (req_valid) begin
          op_q      <= alucode;
          addr_lo_q <= addr[1:0];
          if (req_err) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b1;
          end else begin
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_re    <= is_load(alucode);
            dmem_we    <= align_we;
            dmem_wdata <= align_wdata;
          end
        end
        LSU_ACCESS: begin
          cnt <= 2'b00;
          if (!is_load(op_q)) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        LSU_WAIT: begin
          cnt <= cnt + 2'd1;
          if (cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_data  <= align_load;
            rsp_err   <= 1'b0;
          end
        end
        LSU_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu (MEM_LAT=1) with a scoreboard of expected responses
// and a small byte-writable word memory model.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] dmem_addr;
  logic        dmem_re;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [0:63];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          strobe_cnt = 0;
  int          overlap_cnt = 0;
  int          exp_strobes = 0;

  lsu #(.MEM_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alucode    (alucode),
    .addr       (addr),
    .store_data (store_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: one-cycle read latency, per-byte write enables.
  always @(posedge clk) begin
    if (dmem_re) dmem_rdata <= mem[dmem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (dmem_we[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
  end

  always @(negedge clk) begin
    if (dmem_re || (dmem_we != 4'b0000)) strobe_cnt <= strobe_cnt + 1;
    if (dmem_re && (dmem_we != 4'b0000)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Issues one request at a negedge, pushes its expected response and checks ACCESS-cycle strobes.
  task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                               input logic [3:0] exp_we, input logic exp_re, input logic [31:0] exp_wdata);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    alucode    = code;
    addr       = a;
    store_data = sd;
    t0         = cyc;
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("dmem_we", {28'h0, dmem_we}, {28'h0, exp_we});
    checkOutput("dmem_re", {31'h0, dmem_re}, {31'h0, exp_re});
    if (exp_re || (exp_we != 4'b0000)) begin
      exp_strobes++;
      checkOutput("dmem_addr", dmem_addr, {a[31:2], 2'b00});
    end
    if (exp_we != 4'b0000) checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
  endtask

  task automatic checkResponse();
    exp_t e;
    int   n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checkOutput("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    checkOutput("rsp_data", rsp_data, e.data);
    checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
    checkOutput("latency", cyc - t0, e.lat);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   hi_cnt;
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; alucode = 6'h0; addr = 32'h0; store_data = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_dmem_we", {28'h0, dmem_we}, 32'h0);
    checkOutput("rst_dmem_re", {31'h0, dmem_re}, 32'h0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(ALU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'b1111, 1'b0, 32'hDEADBEEF);
    checkResponse();
    applyStimulus(ALU_SB, 32'h103, 32'h000000A5, 32'h0, 1'b0, 2, 4'b1000, 1'b0, 32'hA5A5A5A5);
    checkResponse();
    applyStimulus(ALU_LW, 32'h100, 32'h0, 32'hA5ADBEEF, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_SW, 32'h100, 32'h12F03456, 32'h0, 1'b0, 2, 4'b1111, 1'b0, 32'h12F03456);
    checkResponse();
    applyStimulus(ALU_LB, 32'h102, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_LBU, 32'h102, 32'h0, 32'h000000F0, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_LH, 32'h102, 32'h0, 32'h000012F0, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_LHU, 32'h100, 32'h0, 32'h00003456, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_LB, 32'h101, 32'h0, 32'h00000034, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_SH, 32'h106, 32'h0000BEEF, 32'h0, 1'b0, 2, 4'b1100, 1'b0, 32'hBEEFBEEF);
    checkResponse();
    applyStimulus(ALU_LH, 32'h106, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(6'h00, 32'h100, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 1'b0, 32'h0);
    checkResponse();
`ifdef LSU_MISALIGN_CHECK_EN
    applyStimulus(ALU_LH, 32'h101, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 1'b0, 32'h0);
    checkResponse();
    applyStimulus(ALU_LW, 32'h102, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 1'b0, 32'h0);
    checkResponse();
`else
    applyStimulus(ALU_LH, 32'h101, 32'h0, 32'h00003456, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    applyStimulus(ALU_LW, 32'h102, 32'h0, 32'h12F03456, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
`endif

    // Backpressure: response held while a second request waits at the input.
    rsp_ready = 1'b0;
    applyStimulus(ALU_LW, 32'h100, 32'h0, 32'h12F03456, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();
    req_valid = 1'b1; alucode = ALU_SW; addr = 32'h104; store_data = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_valid", {31'h0, rsp_valid}, 32'h1);
      checkOutput("hold_data", rsp_data, 32'h12F03456);
      checkOutput("hold_err", {31'h0, rsp_err}, 32'h0);
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'h0);
      checkOutput("hold_no_strobe", {28'h0, dmem_we}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("after_hs_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("after_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    t0 = cyc;
    e.data = 32'h0; e.err = 1'b0; e.lat = 2;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    exp_strobes++;
    checkOutput("b2b_dmem_we", {28'h0, dmem_we}, 32'hF);
    checkOutput("b2b_dmem_wdata", dmem_wdata, 32'h0BADF00D);
    checkOutput("b2b_dmem_addr", dmem_addr, 32'h104);
    checkResponse();
    applyStimulus(ALU_LW, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();

    // Reset during WAIT discards the in-flight load.
    req_valid = 1'b1; alucode = ALU_LW; addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    exp_strobes++;
    checkOutput("rstw_dmem_re", {31'h0, dmem_re}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstw_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) hi_cnt++;
    end
    checkOutput("rstw_no_rsp", hi_cnt, 32'h0);
    applyStimulus(ALU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'b1111, 1'b0, 32'hDEADBEEF);
    checkResponse();
    applyStimulus(ALU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 4'b0000, 1'b1, 32'h0);
    checkResponse();

    repeat (2) @(negedge clk);
    checkOutput("strobe_total", strobe_cnt, exp_strobes);
    checkOutput("strobe_overlap", overlap_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
